ltsm_ctrl: RTL and testbench
============================

LTSM_CTRL -- requirements
Module: ltsm_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low; there are no other clocks or resets.
REQ-002 SHALL take parameter NUM_MB_LANES, default 16, meaning MB data lanes; must be even and >=2.
REQ-003 SHALL take parameter NUM_MB_CLK, default 2, meaning MB clock pins.
REQ-004 SHALL take parameter TIMEOUT_CYCLES, default 800000, meaning per-state timeout (8 ms at 100 MHz).
REQ-005 SHALL have ports:
clk_100MHz  in  1  state clock
reset_n  in  1  async active-low reset
enable_i  in  1  controller enable
start_LT_i  in  1  training start request
sb_tx_msg_o  out  64  SB message to transmit
sb_tx_valid_o  out  1  message valid
sb_tx_ack_i  in  1  transmitter accepted message
sb_rx_msg_i  in  64  received SB message
sb_rx_valid_i  in  1  received message valid, 1-cycle pulse
mbinit_done_i  in  1  MB init sub-phase complete
mbtrain_done_i  in  1  MB train sub-phase complete
lane_fail_i  in  NUM_MB_LANES  per-lane train failure, valid with mbtrain_done_i
linkinit_done_i  in  1  link init complete
sb_tx_sel_o, sb_rx_sel_o, mb_tx_sel_o, mb_rx_sel_o  out  2 each  pin-mux selects
lane_en_o  out  NUM_MB_LANES  active lane mask
state_o  out  3  current state code
link_up_o  out  1  high only in ACTIVE

Function
REQ-006 States, codes: TRAINERROR=0, RESET=1, SBINIT=2, MBINIT=3, MBTRAIN=4, LINKINIT=5, ACTIVE=6; registered, state_o equals code.
REQ-007 RESET -> SBINIT when enable_i && start_LT_i.
REQ-008 SBINIT: send SBINIT_REQ; once REQ acked AND partner SBINIT_REQ received (either order), send SBINIT_DONE; once DONE acked AND partner SBINIT_DONE received -> MBINIT.
REQ-009 Partner messages received before their wait point SHALL be latched in sticky flags, cleared on state exit.
REQ-010 Message format: [7:0] opcode, [15:8] sender state code, [63:16] zero; RX match on [7:0] only, non-matching messages ignored.
REQ-011 TX handshake: msg stable while valid high; transfer when valid && ack on same edge; valid low the cycle after; ack without valid ignored; max one outstanding message.
REQ-012 MBINIT -> MBTRAIN on mbinit_done_i; LINKINIT -> ACTIVE on linkinit_done_i.
REQ-013 MBTRAIN on mbtrain_done_i: no fails -> all lanes, LINKINIT; fails only in upper half -> lower half enabled, LINKINIT; fails only in lower half -> upper half enabled, LINKINIT; fails in both halves -> TRAINERROR.
REQ-014 Timeout counter clears on every state change; reaching TIMEOUT_CYCLES-1 in SBINIT..LINKINIT -> TRAINERROR; not counted in RESET, ACTIVE, TRAINERROR.
REQ-015 enable_i low in any state -> RESET next edge; precedence enable_i low > timeout > normal transition.
REQ-016 TRAINERROR -> RESET when start_LT_i low; held otherwise.
REQ-017 Selects (Z=0, DISABLED=1, INIT=2, COMS=3), listed as SB tx/rx, MB tx/rx: RESET DIS/INIT/Z/INIT; SBINIT COMS/COMS/Z/INIT; MBINIT,MBTRAIN COMS/COMS/INIT/INIT; LINKINIT,ACTIVE COMS/COMS/COMS/COMS; TRAINERROR DIS/Z/Z/Z.
REQ-018 State exit with valid high SHALL drop sb_tx_valid_o next edge; late ack ignored.

Reset
REQ-019 On reset_n low: state RESET, sb_tx_valid_o=0, sb_tx_msg_o=0, flags and counter 0, lane_en_o all ones, link_up_o=0, selects per RESET row.
REQ-020 Reset mid-operation SHALL abort any pending message without waiting for ack.

Structure
REQ-021 Package ltsm_pkg SHALL hold state enum, mux-select enum, opcodes (SBINIT_REQ=8'h01, SBINIT_DONE=8'h02).
REQ-022 Sub-module ltsm_sb_msg_if SHALL own TX valid/ack register and RX opcode match/sticky flags.

Verification
REQ-023 Partner REQ 5 cycles before own ack, then DONE exchange -> MBINIT, mb selects 2/2.
REQ-024 TIMEOUT_CYCLES=100, no partner traffic in SBINIT -> TRAINERROR exactly 100 cycles after entry, sb_rx_sel_o=0.
REQ-025 mbtrain_done_i with lane_fail_i=16'h0100 -> lane_en_o=16'h00FF, LINKINIT; 16'h0101 -> TRAINERROR.
REQ-026 enable_i low same cycle as linkinit_done_i -> RESET, link_up_o stays 0.
REQ-027 reset_n low while sb_tx_valid_o=1 -> valid 0 asynchronously; ack afterwards ignored, state RESET.

Source files
------------

// File: rtl/ltsm_pkg.sv
// ltsm_pkg: shared state, pin-mux select and sideband opcode
// definitions for the link training state machine.
package ltsm_pkg;

    typedef enum logic [2:0] {
        ST_TRAINERROR = 3'd0,
        ST_RESET      = 3'd1,
        ST_SBINIT     = 3'd2,
        ST_MBINIT     = 3'd3,
        ST_MBTRAIN    = 3'd4,
        ST_LINKINIT   = 3'd5,
        ST_ACTIVE     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SEL_Z    = 2'd0,
        SEL_DIS  = 2'd1,
        SEL_INIT = 2'd2,
        SEL_COMS = 2'd3
    } sel_e;

    typedef struct packed {
        sel_e sb_tx;
        sel_e sb_rx;
        sel_e mb_tx;
        sel_e mb_rx;
    } pin_sel_t;

    localparam logic [7:0] OPC_SBINIT_REQ  = 8'h01;
    localparam logic [7:0] OPC_SBINIT_DONE = 8'h02;

    function automatic pin_sel_t pin_sel(state_e st);
        pin_sel_t s;
        case (st)
            ST_RESET:    s = '{SEL_DIS, SEL_INIT, SEL_Z, SEL_INIT};
            ST_SBINIT:   s = '{SEL_COMS, SEL_COMS, SEL_Z, SEL_INIT};
            ST_MBINIT,
            ST_MBTRAIN:  s = '{SEL_COMS, SEL_COMS, SEL_INIT, SEL_INIT};
            ST_LINKINIT,
            ST_ACTIVE:   s = '{SEL_COMS, SEL_COMS, SEL_COMS, SEL_COMS};
            default:     s = '{SEL_DIS, SEL_Z, SEL_Z, SEL_Z};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ltsm_sb_msg_if.sv
// ltsm_sb_msg_if: sideband TX valid/ack register plus sticky
// flags for acked own messages and received partner messages.
module ltsm_sb_msg_if
    import ltsm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        rx_en_i,
    input  logic        send_i,
    input  logic [7:0]  tx_opc_i,
    input  logic [7:0]  tx_state_i,
    output logic [63:0] sb_tx_msg_o,
    output logic        sb_tx_valid_o,
    input  logic        sb_tx_ack_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_opc_i,
    output logic        req_acked_o,
    output logic        done_acked_o,
    output logic        rx_req_o,
    output logic        rx_done_o
);

    logic [63:0] msg_q, msg_d;
    logic        valid_q, valid_d;
    logic        req_ack_q, req_ack_d;
    logic        done_ack_q, done_ack_d;
    logic        rx_req_q, rx_req_d;
    logic        rx_done_q, rx_done_d;
    logic        xfer;

    assign xfer = valid_q && sb_tx_ack_i;

    always_comb begin
        msg_d      = msg_q;
        valid_d    = valid_q;
        req_ack_d  = req_ack_q;
        done_ack_d = done_ack_q;
        rx_req_d   = rx_req_q;
        rx_done_d  = rx_done_q;
        // Leaving the state aborts any pending message outright
        if (clr_i) begin
            valid_d    = 1'b0;
            req_ack_d  = 1'b0;
            done_ack_d = 1'b0;
            rx_req_d   = 1'b0;
            rx_done_d  = 1'b0;
        end else begin
            if (xfer) begin
                valid_d = 1'b0;
                if (msg_q[7:0] == OPC_SBINIT_REQ)
                    req_ack_d = 1'b1;
                if (msg_q[7:0] == OPC_SBINIT_DONE)
                    done_ack_d = 1'b1;
            end else if (send_i && !valid_q) begin
                valid_d = 1'b1;
                msg_d   = {48'd0, tx_state_i, tx_opc_i};
            end
            if (rx_en_i && rx_valid_i) begin
                if (rx_opc_i == OPC_SBINIT_REQ)
                    rx_req_d = 1'b1;
                if (rx_opc_i == OPC_SBINIT_DONE)
                    rx_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msg_q      <= '0;
            valid_q    <= 1'b0;
            req_ack_q  <= 1'b0;
            done_ack_q <= 1'b0;
            rx_req_q   <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            msg_q      <= msg_d;
            valid_q    <= valid_d;
            req_ack_q  <= req_ack_d;
            done_ack_q <= done_ack_d;
            rx_req_q   <= rx_req_d;
            rx_done_q  <= rx_done_d;
        end
    end

    assign sb_tx_msg_o   = msg_q;
    assign sb_tx_valid_o = valid_q;
    assign req_acked_o   = req_ack_q;
    assign done_acked_o  = done_ack_q;
    assign rx_req_o      = rx_req_q;
    assign rx_done_o     = rx_done_q;

endmodule

// File: rtl/ltsm_ctrl.sv
// ltsm_ctrl: link training state machine sequencing sideband init,
// mainband init/train and link init, with per-state timeout.
module ltsm_ctrl
    import ltsm_pkg::*;
#(
    parameter int NUM_MB_LANES   = 16,
    parameter int NUM_MB_CLK     = 2,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic                    clk_100MHz,
    input  logic                    reset_n,
    input  logic                    enable_i,
    input  logic                    start_LT_i,
    output logic [63:0]             sb_tx_msg_o,
    output logic                    sb_tx_valid_o,
    input  logic                    sb_tx_ack_i,
    input  logic [63:0]             sb_rx_msg_i,
    input  logic                    sb_rx_valid_i,
    input  logic                    mbinit_done_i,
    input  logic                    mbtrain_done_i,
    input  logic [NUM_MB_LANES-1:0] lane_fail_i,
    input  logic                    linkinit_done_i,
    output logic [1:0]              sb_tx_sel_o,
    output logic [1:0]              sb_rx_sel_o,
    output logic [1:0]              mb_tx_sel_o,
    output logic [1:0]              mb_rx_sel_o,
    output logic [NUM_MB_LANES-1:0] lane_en_o,
    output logic [2:0]              state_o,
    output logic                    link_up_o
);

    localparam int H  = NUM_MB_LANES / 2;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NUM_MB_LANES-1:0] LoMask =
        {{H{1'b0}}, {H{1'b1}}};
    localparam logic [NUM_MB_LANES-1:0] HiMask = ~LoMask;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_MB_LANES-1:0] lane_en_q, lane_en_d;
    logic counted, timeout, fail_lo, fail_hi, state_chg;
    logic req_acked, done_acked, rx_req, rx_done, send;
    logic [7:0] tx_opc;
    pin_sel_t sel;
    logic unused_ok;

    assign unused_ok = ^{sb_rx_msg_i[63:8], (NUM_MB_CLK > 0)};

    assign counted = state_q inside {ST_SBINIT, ST_MBINIT,
                                     ST_MBTRAIN, ST_LINKINIT};
    assign timeout = counted && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign fail_lo = |lane_fail_i[H-1:0];
    assign fail_hi = |lane_fail_i[NUM_MB_LANES-1:H];
    assign state_chg = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_RESET;
        end else if (timeout) begin
            state_d = ST_TRAINERROR;
        end else begin
            unique case (state_q)
                ST_RESET:
                    if (start_LT_i) state_d = ST_SBINIT;
                ST_SBINIT:
                    if (done_acked && rx_done) state_d = ST_MBINIT;
                ST_MBINIT:
                    if (mbinit_done_i) state_d = ST_MBTRAIN;
                ST_MBTRAIN:
                    if (mbtrain_done_i)
                        state_d = (fail_lo && fail_hi) ?
                                  ST_TRAINERROR : ST_LINKINIT;
                ST_LINKINIT:
                    if (linkinit_done_i) state_d = ST_ACTIVE;
                ST_ACTIVE:
                    state_d = ST_ACTIVE;
                ST_TRAINERROR:
                    if (!start_LT_i) state_d = ST_RESET;
                default:
                    state_d = ST_RESET;
            endcase
        end
    end

    always_comb begin
        cnt_d = '0;
        if (!state_chg && counted)
            cnt_d = cnt_q + 1'b1;
        lane_en_d = lane_en_q;
        // A failing half is dropped; the healthy half carries the link
        if (state_d == ST_RESET)
            lane_en_d = '1;
        else if (state_q == ST_MBTRAIN && state_d == ST_LINKINIT)
            lane_en_d = fail_hi ? LoMask : (fail_lo ? HiMask : '1);
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            lane_en_q <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_en_q <= lane_en_d;
        end
    end

    assign send = (state_q == ST_SBINIT) &&
                  (!req_acked || (rx_req && !done_acked));
    assign tx_opc = req_acked ? OPC_SBINIT_DONE : OPC_SBINIT_REQ;

    ltsm_sb_msg_if u_sb_msg (
        .clk_i         (clk_100MHz),
        .rst_ni        (reset_n),
        .clr_i         (state_chg),
        .rx_en_i       (state_q == ST_SBINIT),
        .send_i        (send),
        .tx_opc_i      (tx_opc),
        .tx_state_i    ({5'd0, state_q}),
        .sb_tx_msg_o   (sb_tx_msg_o),
        .sb_tx_valid_o (sb_tx_valid_o),
        .sb_tx_ack_i   (sb_tx_ack_i),
        .rx_valid_i    (sb_rx_valid_i),
        .rx_opc_i      (sb_rx_msg_i[7:0]),
        .req_acked_o   (req_acked),
        .done_acked_o  (done_acked),
        .rx_req_o      (rx_req),
        .rx_done_o     (rx_done)
    );

    assign sel         = pin_sel(state_q);
    assign sb_tx_sel_o = sel.sb_tx;
    assign sb_rx_sel_o = sel.sb_rx;
    assign mb_tx_sel_o = sel.mb_tx;
    assign mb_rx_sel_o = sel.mb_rx;
    assign lane_en_o   = lane_en_q;
    assign state_o     = state_q;
    assign link_up_o   = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_ltsm_ctrl.sv
// tb_ltsm_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the training sequence.
module tb_ltsm_ctrl;

    localparam int N  = 16;
    localparam int TO = 100;

    logic          clk_100MHz = 1'b0;
    logic          reset_n;
    logic          enable_i, start_LT_i;
    logic [63:0]   sb_tx_msg_o;
    logic          sb_tx_valid_o, sb_tx_ack_i;
    logic [63:0]   sb_rx_msg_i;
    logic          sb_rx_valid_i;
    logic          mbinit_done_i, mbtrain_done_i, linkinit_done_i;
    logic [N-1:0]  lane_fail_i, lane_en_o;
    logic [1:0]    sb_tx_sel_o, sb_rx_sel_o, mb_tx_sel_o, mb_rx_sel_o;
    logic [2:0]    state_o;
    logic          link_up_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    ltsm_ctrl #(
        .NUM_MB_LANES   (N),
        .NUM_MB_CLK     (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_100MHz      (clk_100MHz),
        .reset_n         (reset_n),
        .enable_i        (enable_i),
        .start_LT_i      (start_LT_i),
        .sb_tx_msg_o     (sb_tx_msg_o),
        .sb_tx_valid_o   (sb_tx_valid_o),
        .sb_tx_ack_i     (sb_tx_ack_i),
        .sb_rx_msg_i     (sb_rx_msg_i),
        .sb_rx_valid_i   (sb_rx_valid_i),
        .mbinit_done_i   (mbinit_done_i),
        .mbtrain_done_i  (mbtrain_done_i),
        .lane_fail_i     (lane_fail_i),
        .linkinit_done_i (linkinit_done_i),
        .sb_tx_sel_o     (sb_tx_sel_o),
        .sb_rx_sel_o     (sb_rx_sel_o),
        .mb_tx_sel_o     (mb_tx_sel_o),
        .mb_rx_sel_o     (mb_rx_sel_o),
        .lane_en_o       (lane_en_o),
        .state_o         (state_o),
        .link_up_o       (link_up_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Behavioural model: state codes as plain ints
    int          m_state, m_cnt;
    bit          m_valid, m_req_ok, m_done_ok, m_rx_req, m_rx_done;
    logic [63:0] m_msg;
    logic [N-1:0] m_lanes;

    function automatic logic [7:0] sel_exp(int s);
        case (s)
            1:       return {2'd1, 2'd2, 2'd0, 2'd2};
            2:       return {2'd3, 2'd3, 2'd0, 2'd2};
            3, 4:    return {2'd3, 2'd3, 2'd2, 2'd2};
            5, 6:    return {2'd3, 2'd3, 2'd3, 2'd3};
            default: return {2'd1, 2'd0, 2'd0, 2'd0};
        endcase
    endfunction

    always @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 1; m_cnt = 0; m_valid = 0; m_msg = '0;
            m_req_ok = 0; m_done_ok = 0; m_rx_req = 0; m_rx_done = 0;
            m_lanes = '1;
        end else begin
            int nxt;
            bit cnt_st, lo, hi;
            cnt_st = (m_state >= 2) && (m_state <= 5);
            lo = |lane_fail_i[N/2-1:0];
            hi = |lane_fail_i[N-1:N/2];
            nxt = m_state;
            if (!enable_i) nxt = 1;
            else if (cnt_st && m_cnt == TO - 1) nxt = 0;
            else case (m_state)
                1: if (start_LT_i) nxt = 2;
                2: if (m_done_ok && m_rx_done) nxt = 3;
                3: if (mbinit_done_i) nxt = 4;
                4: if (mbtrain_done_i) nxt = (lo && hi) ? 0 : 5;
                5: if (linkinit_done_i) nxt = 6;
                0: if (!start_LT_i) nxt = 1;
                default: ;
            endcase
            if (nxt != m_state) begin
                m_cnt = 0; m_valid = 0;
                m_req_ok = 0; m_done_ok = 0; m_rx_req = 0; m_rx_done = 0;
                if (nxt == 5)
                    m_lanes = hi ? 16'h00FF : (lo ? 16'hFF00 : 16'hFFFF);
            end else begin
                if (cnt_st) m_cnt++;
                if (m_state == 2) begin
                    if (m_valid && sb_tx_ack_i) begin
                        if (m_msg[7:0] == 8'h01) m_req_ok = 1;
                        else m_done_ok = 1;
                        m_valid = 0;
                    end else if (!m_valid &&
                                 (!m_req_ok || (m_rx_req && !m_done_ok))) begin
                        m_msg = 64'(m_req_ok ? 2 : 1) + 64'(2 * 256);
                        m_valid = 1;
                    end
                    if (sb_rx_valid_i && sb_rx_msg_i[7:0] == 8'h01)
                        m_rx_req = 1;
                    if (sb_rx_valid_i && sb_rx_msg_i[7:0] == 8'h02)
                        m_rx_done = 1;
                end
            end
            if (nxt == 1) m_lanes = '1;
            m_state = nxt;
        end
    end

    always @(negedge clk_100MHz) begin
        if (chk_en) begin
            check("state", 64'(state_o), 64'(m_state));
            check("valid", 64'(sb_tx_valid_o), 64'(m_valid));
            check("msg", sb_tx_msg_o, m_msg);
            check("lanes", 64'(lane_en_o), 64'(m_lanes));
            check("link_up", 64'(link_up_o), 64'(m_state == 6));
            check("sel", 64'({sb_tx_sel_o, sb_rx_sel_o,
                              mb_tx_sel_o, mb_rx_sel_o}),
                  64'(sel_exp(m_state)));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (state_o != 3'(s) && n < budget) begin
            step(1);
            n++;
        end
        check("wait_state", 64'(state_o), 64'(s));
    endtask

    task automatic rx_pulse(input logic [7:0] opc);
        sb_rx_msg_i   = {$urandom, $urandom};
        sb_rx_msg_i[7:0] = opc;
        sb_rx_valid_i = 1'b1;
        step(1);
        sb_rx_valid_i = 1'b0;
    endtask

    task automatic sb_bringup();
        wait_state(2, 10);
        for (int i = 0; i < 40 && state_o != 3'd3; i++) begin
            sb_tx_ack_i   = sb_tx_valid_o;
            sb_rx_valid_i = (i < 2);
            sb_rx_msg_i   = 64'(i == 0 ? 8'h01 : 8'h02);
            step(1);
        end
        sb_tx_ack_i   = 1'b0;
        sb_rx_valid_i = 1'b0;
        check("bringup", 64'(state_o), 64'd3);
    endtask

    initial begin
        reset_n = 1'b0; enable_i = 1'b0; start_LT_i = 1'b0;
        sb_tx_ack_i = 1'b0; sb_rx_msg_i = '0; sb_rx_valid_i = 1'b0;
        mbinit_done_i = 1'b0; mbtrain_done_i = 1'b0;
        linkinit_done_i = 1'b0; lane_fail_i = '0;
        step(3);
        chk_en = 1;
        check("rst_state", 64'(state_o), 64'd1);
        check("rst_valid", 64'(sb_tx_valid_o), 64'd0);
        check("rst_lanes", 64'(lane_en_o), 64'hFFFF);
        reset_n = 1'b1;
        step(1);

        // Partner REQ arrives 5 cycles ahead of our ack
        enable_i = 1'b1; start_LT_i = 1'b1;
        step(1);
        check("sbinit_entry", 64'(state_o), 64'd2);
        step(1);
        check("req_msg", sb_tx_msg_o, 64'h0201);
        rx_pulse(8'h01);
        step(4);
        sb_tx_ack_i = 1'b1;
        step(1);
        sb_tx_ack_i = 1'b0;
        for (int i = 0; i < 10 && !sb_tx_valid_o; i++) step(1);
        check("done_msg", sb_tx_msg_o, 64'h0202);
        rx_pulse(8'h02);
        sb_tx_ack_i = 1'b1;
        step(1);
        sb_tx_ack_i = 1'b0;
        wait_state(3, 10);
        check("mb_tx_sel", 64'(mb_tx_sel_o), 64'd2);
        check("mb_rx_sel", 64'(mb_rx_sel_o), 64'd2);

        // Upper-half failure keeps lower half
        mbinit_done_i = 1'b1; step(1); mbinit_done_i = 1'b0;
        check("mbtrain", 64'(state_o), 64'd4);
        lane_fail_i = 16'h0100; mbtrain_done_i = 1'b1;
        step(1);
        mbtrain_done_i = 1'b0; lane_fail_i = '0;
        check("linkinit", 64'(state_o), 64'd5);
        check("lanes_lo", 64'(lane_en_o), 64'h00FF);

        // Disable wins over linkinit_done
        enable_i = 1'b0; linkinit_done_i = 1'b1;
        step(1);
        linkinit_done_i = 1'b0; enable_i = 1'b1;
        check("dis_state", 64'(state_o), 64'd1);
        check("dis_link", 64'(link_up_o), 64'd0);

        // Failures in both halves
        sb_bringup();
        mbinit_done_i = 1'b1; step(1); mbinit_done_i = 1'b0;
        lane_fail_i = 16'h0101; mbtrain_done_i = 1'b1;
        step(1);
        mbtrain_done_i = 1'b0; lane_fail_i = '0;
        check("both_fail", 64'(state_o), 64'd0);
        start_LT_i = 1'b0;
        step(1);
        check("te_exit", 64'(state_o), 64'd1);

        // Silent partner in SBINIT times out
        start_LT_i = 1'b1;
        wait_state(2, 5);
        step(TO - 1);
        check("to_not_yet", 64'(state_o), 64'd2);
        step(1);
        check("to_state", 64'(state_o), 64'd0);
        check("to_sb_rx_sel", 64'(sb_rx_sel_o), 64'd0);
        start_LT_i = 1'b0;
        step(1);

        // Async reset with a message pending
        start_LT_i = 1'b1;
        wait_state(2, 5);
        step(1);
        check("pend_valid", 64'(sb_tx_valid_o), 64'd1);
        start_LT_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", 64'(sb_tx_valid_o), 64'd0);
        check("async_state", 64'(state_o), 64'd1);
        @(posedge clk_100MHz);
        #1;
        reset_n = 1'b1; sb_tx_ack_i = 1'b1;
        step(1);
        sb_tx_ack_i = 1'b0;
        check("late_ack_state", 64'(state_o), 64'd1);
        check("late_ack_valid", 64'(sb_tx_valid_o), 64'd0);

        for (int c = 0; c < 4000; c++) begin
            int k;
            enable_i        = ($urandom_range(0, 99) != 0);
            start_LT_i      = ($urandom_range(0, 9) != 0);
            sb_tx_ack_i     = 1'($urandom_range(0, 1));
            sb_rx_valid_i   = ($urandom_range(0, 3) == 0);
            sb_rx_msg_i     = {$urandom, $urandom};
            k = $urandom_range(0, 2);
            if (k < 2) sb_rx_msg_i[7:0] = 8'(k + 1);
            mbinit_done_i   = ($urandom_range(0, 7) == 0);
            mbtrain_done_i  = ($urandom_range(0, 7) == 0);
            linkinit_done_i = ($urandom_range(0, 7) == 0);
            k = $urandom_range(0, 3);
            lane_fail_i = '0;
            if (k == 1 || k == 3)
                lane_fail_i[N-1:N/2] = 8'($urandom_range(1, 255));
            if (k == 2 || k == 3)
                lane_fail_i[N/2-1:0] = 8'($urandom_range(1, 255));
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
